pcs_loopback_ctrl: RTL and testbench
====================================

Name: pcs_loopback_ctrl

Overview:
- Sequences entry to and exit from PCS RX->TX loopback for FPGA testing. Owns the mux that feeds the TX PCS encoder from either the MAC or the loopback path.
- Switching happens only on frame boundaries. Idle blocks fill every transition gap. Loopback is gated on stable RX block lock.
- Loss of lock in the middle of a looped frame aborts the frame with an error block.
- Sits in the tx_clk domain, between the loopback flop stage and the TX PCS.

Parameters:
DATA_W, 64, data width per block
KEEP_W, DATA_W/8, byte-keep width
LOCK_STABLE_N, 16, consecutive locked cycles required before arming loopback (at least 1)
CNT_W, 16, width of the looped-frame counter

Ports:
clk  input  1  tx_clk domain clock
nreset  input  1  synchronous active-low reset
lb_req_i  input  1  level request: 1 = loopback wanted, 0 = normal MAC path
rx_lock_i  input  1  RX block lock, already synchronised to clk
tx_ready_i  input  1  TX PCS accepts a block this cycle (gearbox stall when 0)
mac_ctrl_i / mac_idle_i / mac_term_i / mac_err_i / mac_start_i  input  1 each  MAC block flags
mac_data_i  input  DATA_W  MAC block data
mac_keep_i  input  KEEP_W  MAC byte keep
mac_ready_o  output  1  MAC block consumed this cycle
lb_ctrl_i / lb_idle_i / lb_term_i / lb_err_i / lb_start_i  input  1 each  loopback block flags
lb_data_i  input  DATA_W  loopback block data
lb_keep_i  input  KEEP_W  loopback byte keep
pcs_tx_ctrl_o / pcs_tx_idle_o / pcs_tx_term_o / pcs_tx_err_o / pcs_tx_start_o  output  1 each  block flags to TX PCS
pcs_tx_data_o  output  DATA_W  block data to TX PCS
pcs_tx_keep_o  output  KEEP_W  byte keep to TX PCS
lb_active_o  output  1  state == LOOP
lb_abort_o  output  1  one-cycle pulse when a looped frame is aborted
lb_frame_cnt_o  output  CNT_W  number of looped frames that completed with a term block (saturating)

Behaviour:
- Idle block definition: ctrl=1, idle=1, term=err=start=0, data=0, keep=0.
- Outputs are registered, one-cycle latency from the selected source. Outputs update only when tx_ready_i=1; otherwise they hold.
- mac_ready_o = tx_ready_i and (state==NORMAL or MAC frame in progress during DRAIN_MAC). It is combinational.
- Frame tracking, separately for MAC and loopback:
  - in_frame is set on an accepted start.
  - in_frame is cleared on an accepted term.
  - start and term in the same block leaves in_frame=0.
- States:
  - NORMAL: pass the MAC source. If lb_req_i=1: go to ARM when MAC in_frame=0 and the current block is not a start; otherwise go to DRAIN_MAC.
  - DRAIN_MAC: pass the MAC source until the accepted term, then go to ARM. lb_req_i dropping here has no effect until the frame ends; then go to NORMAL instead.
  - ARM: output idle; mac_ready_o=0. The lock counter increments while rx_lock_i=1 and clears to 0 when rx_lock_i=0. Go to LOOP when counter ≥ LOCK_STABLE_N-1, rx_lock_i=1, and the loopback block is not mid-frame. A loopback block is mid-frame when loopback in_frame=1, or when it is a non-idle, non-start data block. lb_req_i=0 -> NORMAL.
  - LOOP: pass the loopback source.
    - lb_req_i=0 with loopback in_frame=0 -> NORMAL.
    - lb_req_i=0 mid-frame -> stay until term, then NORMAL.
    - rx_lock_i=0 with loopback in_frame=1: emit one error block (ctrl=1, err=1, other flags 0, data/keep 0), pulse lb_abort_o, clear in_frame, go to ARM with the counter cleared.
    - rx_lock_i=0 with in_frame=0: go to ARM without an error block.
- lb_frame_cnt_o increments on each accepted loopback term in LOOP and saturates at all-ones. It is cleared only by reset.
- Blocks arriving on the loopback source while tx_ready_i=0 are dropped; the upstream gearbox is reset-aligned so this does not happen in operation. Blocks on the MAC source are held by mac_ready_o.
- Simultaneous lb_req_i rise and rx_lock_i loss: lock dominates (stay in ARM).
- Reset (synchronous, any state, including mid-frame):
  - State -> NORMAL; counters and in_frame flags -> 0.
  - Outputs -> idle block; lb_active_o=0, lb_abort_o=0, lb_frame_cnt_o=0.

Test Plan:
- Reset, lb_req_i=0, MAC sends start/data/term -> after 1 cycle the TX outputs match the MAC blocks exactly; lb_active_o=0.
- lb_req_i=1 raised on the second block of a 5-block MAC frame -> MAC frame completes intact, then ≥1 idle block. rx_lock_i high for 16 cycles -> lb_active_o=1 and loopback blocks are forwarded.
- In LOOP, 3 looped frames -> lb_frame_cnt_o=3. With CNT_W=2, 5 frames -> count saturates at 3.
- In LOOP, rx_lock_i drops on block 2 of a looped frame -> next output is an error block, lb_abort_o pulses for 1 cycle, state is ARM, and idle blocks follow.
- rx_lock_i toggles low once during ARM after 10 locked cycles -> LOOP is entered only after a further 16 contiguous locked cycles.
- tx_ready_i=0 for 1 cycle mid MAC frame -> outputs hold, mac_ready_o=0, no block lost or duplicated. Reset asserted in LOOP mid-frame -> outputs go to idle next cycle and state is NORMAL.

Source files
------------

// File: rtl/pcs_loopback_ctrl.sv
// PCS RX->TX loopback sequencer: picks the MAC or looped block stream for the TX PCS,
// switching only on frame boundaries and only once RX block lock has been stable.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// NORMAL    | MAC source forwarded to the TX PCS
// DRAIN_MAC | loopback requested, finishing the MAC frame already in flight
// ARM       | idle blocks emitted while RX lock is qualified
// LOOP      | loopback source forwarded to the TX PCS
module pcs_loopback_ctrl #(
    parameter int DATA_W        = 64,
    parameter int KEEP_W        = DATA_W / 8,
    parameter int LOCK_STABLE_N = 16,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              lb_req_i,
    input  logic              rx_lock_i,
    input  logic              tx_ready_i,
    input  logic              mac_ctrl_i,
    input  logic              mac_idle_i,
    input  logic              mac_term_i,
    input  logic              mac_err_i,
    input  logic              mac_start_i,
    input  logic [DATA_W-1:0] mac_data_i,
    input  logic [KEEP_W-1:0] mac_keep_i,
    output logic              mac_ready_o,
    input  logic              lb_ctrl_i,
    input  logic              lb_idle_i,
    input  logic              lb_term_i,
    input  logic              lb_err_i,
    input  logic              lb_start_i,
    input  logic [DATA_W-1:0] lb_data_i,
    input  logic [KEEP_W-1:0] lb_keep_i,
    output logic              pcs_tx_ctrl_o,
    output logic              pcs_tx_idle_o,
    output logic              pcs_tx_term_o,
    output logic              pcs_tx_err_o,
    output logic              pcs_tx_start_o,
    output logic [DATA_W-1:0] pcs_tx_data_o,
    output logic [KEEP_W-1:0] pcs_tx_keep_o,
    output logic              lb_active_o,
    output logic              lb_abort_o,
    output logic [CNT_W-1:0]  lb_frame_cnt_o
);

    localparam int              LK_W   = (LOCK_STABLE_N > 1) ? $clog2(LOCK_STABLE_N) : 1;
    localparam logic [LK_W-1:0] LK_MAX = LK_W'(LOCK_STABLE_N - 1);

    // Flag bundles are ordered {ctrl, idle, term, err, start}.
    localparam logic [4:0] FLG_IDLE = 5'b11000;
    localparam logic [4:0] FLG_ERR  = 5'b10010;

    typedef enum logic [1:0] {
        S_NORMAL    = 2'd0,
        S_DRAIN_MAC = 2'd1,
        S_ARM       = 2'd2,
        S_LOOP      = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_mac_in_frame;
    logic                r_lb_in_frame;
    logic [LK_W-1:0]     r_lock_cnt;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic [4:0]          r_flags;
    logic [DATA_W-1:0]   r_data;
    logic [KEEP_W-1:0]   r_keep;
    logic                r_abort;

    logic [4:0]          w_mac_flags;
    logic [4:0]          w_lb_flags;
    logic [4:0]          w_sel_flags;
    logic [DATA_W-1:0]   w_sel_data;
    logic [KEEP_W-1:0]   w_sel_keep;
    logic                w_mac_ready;
    logic                w_lb_mid;
    logic                w_go_loop;
    logic                w_lb_fwd;
    logic                w_abort;
    logic                w_cnt_inc;

    assign w_mac_flags = {mac_ctrl_i, mac_idle_i, mac_term_i, mac_err_i, mac_start_i};
    assign w_lb_flags  = {lb_ctrl_i, lb_idle_i, lb_term_i, lb_err_i, lb_start_i};

    assign w_mac_ready = tx_ready_i &
                         ((r_state == S_NORMAL) | ((r_state == S_DRAIN_MAC) & r_mac_in_frame));

    // Anything other than an idle or a start is treated as the inside of a frame.
    assign w_lb_mid  = r_lb_in_frame | (~lb_idle_i & ~lb_start_i);

    assign w_go_loop = (r_state == S_ARM) & lb_req_i & rx_lock_i &
                       (r_lock_cnt >= LK_MAX) & ~w_lb_mid;

    // In LOOP a block is forwarded unless lock is lost or we are leaving between frames.
    assign w_lb_fwd  = (r_state == S_LOOP) & rx_lock_i & (lb_req_i | r_lb_in_frame);

    assign w_abort   = tx_ready_i & (r_state == S_LOOP) & ~rx_lock_i & r_lb_in_frame;
    assign w_cnt_inc = tx_ready_i & w_lb_fwd & lb_term_i;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_flags = FLG_IDLE;
        w_sel_data  = '0;
        w_sel_keep  = '0;
        case (r_state)
            S_NORMAL: begin
                if (w_mac_ready) begin
                    w_sel_flags = w_mac_flags;
                    w_sel_data  = mac_data_i;
                    w_sel_keep  = mac_keep_i;
                end
                if (tx_ready_i && lb_req_i) begin
                    w_state_nxt = (!r_mac_in_frame && !mac_start_i) ? S_ARM : S_DRAIN_MAC;
                end
            end
            S_DRAIN_MAC: begin
                if (w_mac_ready) begin
                    w_sel_flags = w_mac_flags;
                    w_sel_data  = mac_data_i;
                    w_sel_keep  = mac_keep_i;
                end
                // A single-block frame can leave us here with nothing left to drain.
                if (tx_ready_i && (!r_mac_in_frame || mac_term_i)) begin
                    w_state_nxt = lb_req_i ? S_ARM : S_NORMAL;
                end
            end
            S_ARM: begin
                // The boundary block seen on the arming cycle goes out so a start is not lost.
                if (w_go_loop) begin
                    w_sel_flags = w_lb_flags;
                    w_sel_data  = lb_data_i;
                    w_sel_keep  = lb_keep_i;
                end
                if (tx_ready_i) begin
                    if (!lb_req_i) begin
                        w_state_nxt = S_NORMAL;
                    end else if (w_go_loop) begin
                        w_state_nxt = S_LOOP;
                    end
                end
            end
            S_LOOP: begin
                if (w_lb_fwd) begin
                    w_sel_flags = w_lb_flags;
                    w_sel_data  = lb_data_i;
                    w_sel_keep  = lb_keep_i;
                end else if (!rx_lock_i && r_lb_in_frame) begin
                    w_sel_flags = FLG_ERR;
                end
                if (tx_ready_i) begin
                    if (!rx_lock_i) begin
                        w_state_nxt = S_ARM;
                    end else if (!lb_req_i && (!r_lb_in_frame || lb_term_i)) begin
                        w_state_nxt = S_NORMAL;
                    end
                end
            end
            default: begin
                w_state_nxt = S_NORMAL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state        <= S_NORMAL;
            r_mac_in_frame <= 1'b0;
            r_lb_in_frame  <= 1'b0;
            r_lock_cnt     <= '0;
            r_frame_cnt    <= '0;
            r_flags        <= FLG_IDLE;
            r_data         <= '0;
            r_keep         <= '0;
            r_abort        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_abort <= w_abort;

            if (w_mac_ready) begin
                if (mac_term_i) begin
                    r_mac_in_frame <= 1'b0;
                end else if (mac_start_i) begin
                    r_mac_in_frame <= 1'b1;
                end
            end

            if (w_abort) begin
                r_lb_in_frame <= 1'b0;
            end else if (tx_ready_i) begin
                if (lb_term_i) begin
                    r_lb_in_frame <= 1'b0;
                end else if (lb_start_i) begin
                    r_lb_in_frame <= 1'b1;
                end
            end

            // Only qualifies lock while arming; any other state leaves it at zero.
            if ((r_state == S_ARM) && rx_lock_i) begin
                r_lock_cnt <= (r_lock_cnt == LK_MAX) ? r_lock_cnt : r_lock_cnt + 1'b1;
            end else begin
                r_lock_cnt <= '0;
            end

            if (w_cnt_inc && (r_frame_cnt != '1)) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end

            if (tx_ready_i) begin
                r_flags <= w_sel_flags;
                r_data  <= w_sel_data;
                r_keep  <= w_sel_keep;
            end
        end
    end

    assign mac_ready_o    = w_mac_ready;
    assign pcs_tx_ctrl_o  = r_flags[4];
    assign pcs_tx_idle_o  = r_flags[3];
    assign pcs_tx_term_o  = r_flags[2];
    assign pcs_tx_err_o   = r_flags[1];
    assign pcs_tx_start_o = r_flags[0];
    assign pcs_tx_data_o  = r_data;
    assign pcs_tx_keep_o  = r_keep;
    assign lb_active_o    = (r_state == S_LOOP);
    assign lb_abort_o     = r_abort;
    assign lb_frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_pcs_loopback_ctrl.sv
// Scoreboard bench for pcs_loopback_ctrl: directed block streams push hand-computed
// expected TX blocks and status; an independent monitor pops and compares each cycle.
module tb_pcs_loopback_ctrl;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int CW = 2;

    typedef struct packed {
        logic [4:0]    f;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
    } blk_t;

    typedef struct {
        blk_t          o;
        logic          mr;
        logic          mr_chk;
        logic          act;
        logic          abt;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic lb_req = 1'b0;
    logic rx_lock = 1'b0;
    logic tx_ready = 1'b1;
    blk_t mac_b;
    blk_t lb_b;

    logic          mac_ready;
    logic          p_ctrl, p_idle, p_term, p_err, p_start;
    logic [DW-1:0] p_data;
    logic [KW-1:0] p_keep;
    logic          act, abt;
    logic [CW-1:0] cnt;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   item_idx = 0;

    logic          n_rst, n_req, n_lock, n_rdy, n_mrchk;
    logic          x_act, x_abt;
    logic [CW-1:0] x_cnt;

    always #5 clk = ~clk;

    pcs_loopback_ctrl #(
        .DATA_W(DW), .KEEP_W(KW), .LOCK_STABLE_N(16), .CNT_W(CW)
    ) dut (
        .clk(clk), .nreset(nreset), .lb_req_i(lb_req), .rx_lock_i(rx_lock),
        .tx_ready_i(tx_ready),
        .mac_ctrl_i(mac_b.f[4]), .mac_idle_i(mac_b.f[3]), .mac_term_i(mac_b.f[2]),
        .mac_err_i(mac_b.f[1]), .mac_start_i(mac_b.f[0]),
        .mac_data_i(mac_b.d), .mac_keep_i(mac_b.k), .mac_ready_o(mac_ready),
        .lb_ctrl_i(lb_b.f[4]), .lb_idle_i(lb_b.f[3]), .lb_term_i(lb_b.f[2]),
        .lb_err_i(lb_b.f[1]), .lb_start_i(lb_b.f[0]),
        .lb_data_i(lb_b.d), .lb_keep_i(lb_b.k),
        .pcs_tx_ctrl_o(p_ctrl), .pcs_tx_idle_o(p_idle), .pcs_tx_term_o(p_term),
        .pcs_tx_err_o(p_err), .pcs_tx_start_o(p_start),
        .pcs_tx_data_o(p_data), .pcs_tx_keep_o(p_keep),
        .lb_active_o(act), .lb_abort_o(abt), .lb_frame_cnt_o(cnt)
    );

    function automatic blk_t mk(input logic [4:0] f, input logic [DW-1:0] d, input logic [KW-1:0] k);
        blk_t b;
        b.f = f;
        b.d = d;
        b.k = k;
        return b;
    endfunction

    function automatic blk_t bi();                      return mk(5'b11000, '0, '0);     endfunction
    function automatic blk_t be();                      return mk(5'b10010, '0, '0);     endfunction
    function automatic blk_t bs(input logic [DW-1:0] d);  return mk(5'b10001, d, 8'hFF); endfunction
    function automatic blk_t bd(input logic [DW-1:0] d);  return mk(5'b00000, d, 8'hFF); endfunction
    function automatic blk_t bt(input logic [DW-1:0] d);  return mk(5'b10100, d, 8'h0F); endfunction
    function automatic blk_t bst(input logic [DW-1:0] d); return mk(5'b10101, d, 8'h03); endfunction

    task automatic chk(input string name, input int idx, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s item %0d: got %0h expected %0h", name, idx, got, want);
        end
    endtask

    // One block-time: drive both sources and queue what the DUT must show after the edge.
    task automatic cyc(input blk_t mb, input blk_t lbb, input blk_t eo, input logic emr);
        exp_t e;
        @(negedge clk);
        mac_b    = mb;
        lb_b     = lbb;
        nreset   = n_rst;
        lb_req   = n_req;
        rx_lock  = n_lock;
        tx_ready = n_rdy;
        e.o      = eo;
        e.mr     = emr;
        e.mr_chk = n_mrchk;
        e.act    = x_act;
        e.abt    = x_abt;
        e.cnt    = x_cnt;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        blk_t got;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                item_idx++;
                if (e.mr_chk) chk("mac_ready", item_idx, 128'(mac_ready), 128'(e.mr));
                @(posedge clk);
                #1;
                got = mk({p_ctrl, p_idle, p_term, p_err, p_start}, p_data, p_keep);
                chk("tx_block", item_idx, 128'(got), 128'(e.o));
                chk("status", item_idx, 128'({act, abt, cnt}), 128'({e.act, e.abt, e.cnt}));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        mac_b   = bi();
        lb_b    = bi();
        n_rst   = 1'b0; n_req = 1'b0; n_lock = 1'b0; n_rdy = 1'b1; n_mrchk = 1'b0;
        x_act   = 1'b0; x_abt = 1'b0; x_cnt = '0;

        repeat (2) cyc(bi(), bi(), bi(), 1'b0);
        n_rst = 1'b1; n_mrchk = 1'b1;

        // plain MAC pass-through
        cyc(bs(64'hA1), bi(), bs(64'hA1), 1'b1);
        cyc(bd(64'hA2), bi(), bd(64'hA2), 1'b1);
        cyc(bt(64'hA3), bi(), bt(64'hA3), 1'b1);
        cyc(bi(),       bi(), bi(),       1'b1);

        // request on the second block of a 5-block frame: frame drains intact
        cyc(bs(64'hB1), bi(), bs(64'hB1), 1'b1);
        n_req = 1'b1;
        cyc(bd(64'hB2), bi(), bd(64'hB2), 1'b1);
        cyc(bd(64'hB3), bi(), bd(64'hB3), 1'b1);
        cyc(bd(64'hB4), bi(), bd(64'hB4), 1'b1);
        cyc(bt(64'hB5), bi(), bt(64'hB5), 1'b1);

        // ARM: MAC holds its next start; lock 10 cycles, one drop, then 16 contiguous
        cyc(bs(64'hC1), bi(), bi(), 1'b0);
        n_lock = 1'b1;
        repeat (10) cyc(bs(64'hC1), bi(), bi(), 1'b0);
        n_lock = 1'b0;
        cyc(bs(64'hC1), bi(), bi(), 1'b0);
        n_lock = 1'b1;
        repeat (15) cyc(bs(64'hC1), bi(), bi(), 1'b0);
        x_act = 1'b1;
        cyc(bs(64'hC1), bi(), bi(), 1'b0);

        // LOOP: five looped frames, counter saturates at 3 with a 2-bit counter
        cyc(bs(64'hC1), bs(64'hD1), bs(64'hD1), 1'b0);
        cyc(bs(64'hC1), bd(64'hD2), bd(64'hD2), 1'b0);
        x_cnt = 2'd1;
        cyc(bs(64'hC1), bt(64'hD3), bt(64'hD3), 1'b0);
        cyc(bs(64'hC1), bs(64'hD4), bs(64'hD4), 1'b0);
        x_cnt = 2'd2;
        cyc(bs(64'hC1), bt(64'hD5), bt(64'hD5), 1'b0);
        x_cnt = 2'd3;
        cyc(bs(64'hC1), bst(64'hD6), bst(64'hD6), 1'b0);
        cyc(bs(64'hC1), bs(64'hD7), bs(64'hD7), 1'b0);
        cyc(bs(64'hC1), bt(64'hD8), bt(64'hD8), 1'b0);
        cyc(bs(64'hC1), bs(64'hD9), bs(64'hD9), 1'b0);
        cyc(bs(64'hC1), bd(64'hDA), bd(64'hDA), 1'b0);
        cyc(bs(64'hC1), bt(64'hDB), bt(64'hDB), 1'b0);

        // lock lost on block 2 of a looped frame: error block, abort pulse, back to ARM
        cyc(bs(64'hC1), bs(64'hE1), bs(64'hE1), 1'b0);
        n_lock = 1'b0; x_act = 1'b0; x_abt = 1'b1;
        cyc(bs(64'hC1), bd(64'hE2), be(), 1'b0);
        x_abt = 1'b0;
        cyc(bs(64'hC1), bd(64'hE3), bi(), 1'b0);
        cyc(bs(64'hC1), bt(64'hE4), bi(), 1'b0);

        // request dropped while arming: return to NORMAL
        n_req = 1'b0;
        cyc(bs(64'hC1), bi(), bi(), 1'b0);

        // one-cycle TX stall mid MAC frame: output holds, nothing lost or repeated
        cyc(bs(64'hC1), bi(), bs(64'hC1), 1'b1);
        n_rdy = 1'b0;
        cyc(bd(64'hC2), bi(), bs(64'hC1), 1'b0);
        n_rdy = 1'b1;
        cyc(bd(64'hC2), bi(), bd(64'hC2), 1'b1);
        cyc(bt(64'hC3), bi(), bt(64'hC3), 1'b1);
        cyc(bi(),       bi(), bi(),       1'b1);

        // back into LOOP, then reset in the middle of a looped frame
        n_req = 1'b1; n_lock = 1'b1;
        cyc(bi(), bi(), bi(), 1'b1);
        repeat (15) cyc(bi(), bi(), bi(), 1'b0);
        x_act = 1'b1;
        cyc(bi(), bi(), bi(), 1'b0);
        cyc(bi(), bs(64'hF1), bs(64'hF1), 1'b0);
        cyc(bi(), bd(64'hF2), bd(64'hF2), 1'b0);
        n_rst = 1'b0; n_mrchk = 1'b0; x_act = 1'b0; x_cnt = '0;
        cyc(bi(), bd(64'hF3), bi(), 1'b0);
        n_rst = 1'b1; n_mrchk = 1'b1; n_req = 1'b0; n_lock = 1'b0;
        cyc(bs(64'h91), bi(), bs(64'h91), 1'b1);
        cyc(bt(64'h92), bi(), bt(64'h92), 1'b1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", item_idx, 128'(q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
